// File: rtl/sr_flag_arbiter_pkg.sv
// sr_flag_arbiter_pkg: shared encodings for the SR flag arbiter.
//   op_e    : per-requester operation code carried on the op bus
//   state_e : sequencer states (IDLE -> SETUP -> STROBE -> RELEASE -> DONE)
package sr_flag_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DONE
  } state_e;

  // SET and CLEAR are the only ops that touch the bank.
  function automatic logic op_is_write(input op_e o);
    return (o == OP_SET) || (o == OP_CLR);
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr.sv
// rr_arbiter: combinational round-robin search.
//   req     in  N      pending requests
//   ptr     in  W      first requester to consider
//   en      in  1      search enable; gnt is all-zero when low
//   gnt     out N      one-hot winner (first req at or after ptr)
//   gnt_idx out W      index of the winner (0 when nothing granted)
// The caller registers the result.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic         found;
  logic [W-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (en && !found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter + sequencer for a bank of gated SR latches.
//   clk, rst_n  clock, async active-low reset
//   req/op/idx  per-requester request, op (2b) and flag index (IDX_W b)
//   ack         one-cycle completion pulse to the granted requester (DONE only)
//   err, rd_q   valid with ack: op failed / Q of the addressed flag
//   busy        sequencer not idle
//   lat_s/r/c   registered S, R, C drives to the bank
//   lat_q       Q readback from the bank
// Write sequence: S/R set up with C low, C strobed STROBE_CYC cycles, C
// dropped while S/R still held, then S/R released as Q is checked.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int NFLAGS     = 8,
  parameter int STROBE_CYC = 2,
  parameter int IDX_W      = (NFLAGS > 1) ? $clog2(NFLAGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [IDX_W*NREQ-1:0] idx,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  rd_q,
  output logic                  busy,
  output logic [NFLAGS-1:0]     lat_s,
  output logic [NFLAGS-1:0]     lat_r,
  output logic [NFLAGS-1:0]     lat_c,
  input  logic [NFLAGS-1:0]     lat_q
);

  localparam int PTR_W = $clog2(NREQ);

  state_e             state_q;
  op_e                op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NREQ-1:0]    gnt_q;
  logic [PTR_W-1:0]   gidx_q, ptr_q, ptr_d;
  logic [3:0]         cnt_q;
  logic [NFLAGS-1:0]  lat_s_q, lat_r_q, lat_c_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [1:0]         op_arr  [NREQ];
  logic [IDX_W-1:0]   idx_arr [NREQ];
  op_e                op_sel;
  logic [IDX_W-1:0]   idx_sel;
  logic               wr_sel, wr_q, done, q_sel;

  // One-hot flag select; an out-of-range index selects nothing.
  function automatic logic [NFLAGS-1:0] flag_oh(input logic [IDX_W-1:0] i);
    logic [NFLAGS-1:0] v;
    v = '0;
    for (int f = 0; f < NFLAGS; f++) if (int'(i) == f) v[f] = 1'b1;
    return v;
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] i);
    return int'(i) < NFLAGS;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]  = op[2*g +: 2];
    assign idx_arr[g] = idx[IDX_W*g +: IDX_W];
  end

  rr_arbiter #(.N(NREQ), .W(PTR_W)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .en      (state_q == S_IDLE),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign op_sel  = op_e'(op_arr[arb_idx]);
  assign idx_sel = idx_arr[arb_idx];
  assign wr_sel  = op_is_write(op_sel) && idx_ok(idx_sel);
  assign wr_q    = op_is_write(op_q) && idx_ok(idx_q);
  assign ptr_d   = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      idx_q   <= '0;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lat_s_q <= '0;
      lat_r_q <= '0;
      lat_c_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (|req) begin
          gnt_q   <= arb_gnt;
          gidx_q  <= arb_idx;
          op_q    <= op_sel;
          idx_q   <= idx_sel;
          // S/R become visible in SETUP, one cycle ahead of C.
          if (wr_sel) begin
            lat_s_q <= (op_sel == OP_SET) ? flag_oh(idx_sel) : '0;
            lat_r_q <= (op_sel == OP_CLR) ? flag_oh(idx_sel) : '0;
          end
          state_q <= S_SETUP;
        end
        S_SETUP: if (wr_q) begin
          lat_c_q <= flag_oh(idx_q);
          cnt_q   <= 4'(STROBE_CYC - 1);
          state_q <= S_STROBE;
        end else begin
          state_q <= S_DONE;
        end
        S_STROBE: if (cnt_q == '0) begin
          lat_c_q <= '0;
          state_q <= S_RELEASE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        // C is already low here; S/R drop one cycle later for hold margin.
        S_RELEASE: begin
          lat_s_q <= '0;
          lat_r_q <= '0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Completion outputs decode the registered state; Q is sampled during DONE.
  assign done  = (state_q == S_DONE);
  assign q_sel = |(lat_q & flag_oh(idx_q));
  assign ack   = done ? gnt_q : '0;
  assign rd_q  = done & q_sel;
  assign err   = done & ((op_q == OP_RSV) || !idx_ok(idx_q) ||
                         (wr_q && (q_sel != (op_q == OP_SET))));
  assign busy  = (state_q != S_IDLE);
  assign lat_s = lat_s_q;
  assign lat_r = lat_r_q;
  assign lat_c = lat_c_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed + randomized bench for sr_flag_arbiter.
// A 6-flag bank is used so that 3-bit indices 6 and 7 are out of range;
// with 8 flags every representable index would be legal.
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 6;
  localparam int SC = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [2*NR-1:0] op;
  logic [IW*NR-1:0] idx;
  logic [NR-1:0] ack;
  logic          err, rd_q, busy;
  logic [NF-1:0] lat_s, lat_r, lat_c, lat_q;

  logic [1:0]    op_a  [NR] = '{default: 2'b00};
  logic [IW-1:0] idx_a [NR] = '{default: '0};

  // Behavioural latch bank: while C is high, S sets and R clears Q.
  logic [NF-1:0] bank = '0;
  logic [NF-1:0] stuck0 = '0;
  assign lat_q = bank & ~stuck0;

  always @(posedge clk)
    for (int i = 0; i < NF; i++)
      if (lat_c[i]) begin
        if (lat_s[i]) bank[i] <= 1'b1;
        else if (lat_r[i]) bank[i] <= 1'b0;
      end

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign op[2*g +: 2]    = op_a[g];
    assign idx[IW*g +: IW] = idx_a[g];
  end

  sr_flag_arbiter #(.NREQ(NR), .NFLAGS(NF), .STROBE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .ack(ack), .err(err), .rd_q(rd_q), .busy(busy),
    .lat_s(lat_s), .lat_r(lat_r), .lat_c(lat_c), .lat_q(lat_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  bit mflag [NF] = '{default: 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first pending requester at or after p.
  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (p + i) % NR;
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  always @(negedge clk)
    if (rst_n) begin
      chk("inv_s_and_r", 32'(lat_s & lat_r), 0);
      chk("inv_c_onehot0", 32'($onehot0(lat_c)), 1);
    end

  task automatic set_op(input int r, input logic [1:0] o, input logic [IW-1:0] ix);
    op_a[r]  = o;
    idx_a[r] = ix;
  endtask

  task automatic do_reset(input bit check_out);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    if (check_out) begin
      chk("rst_ack",   32'(ack),   0);
      chk("rst_err",   32'(err),   0);
      chk("rst_rd_q",  32'(rd_q),  0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_lat_s", 32'(lat_s), 0);
      chk("rst_lat_r", 32'(lat_r), 0);
      chk("rst_lat_c", 32'(lat_c), 0);
    end
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // Wait for the next grant, predict its outcome, follow it to ack and check.
  task automatic serve(input string tag, input bit hold, input bit early);
    int n, w, o, ix, lat, lat_exp, c_any, c_ix;
    bit wr, e_err, e_rd;
    logic [IW-1:0] ixv;
    logic [NF-1:0] oh;
    n = 0;
    while (!(busy === 1'b0 && req != '0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant_wait"}, 32'(n < 50), 1);
    w = pick(req, ptr_m);
    if (w < 0) w = 0;
    o   = int'(op_a[w]);
    ixv = idx_a[w];
    ix  = int'(ixv);
    oh  = (ix < NF) ? (NF'(1) << ix) : '0;
    wr  = (o == 1 || o == 2) && ix < NF;
    e_err = (o == 3) || (ix >= NF);
    if (wr) begin
      if (!stuck0[ixv]) mflag[ix] = (o == 1);
      e_err = (mflag[ix] != (o == 1));
    end
    e_rd    = (ix < NF) ? mflag[ix] : 1'b0;
    lat_exp = wr ? SC + 3 : 2;
    lat = 0; c_any = 0; c_ix = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat_c != '0) c_any++;
      if ((lat_c & oh) != '0) c_ix++;
      if (lat == 1) begin
        chk({tag, "_setup_s"}, 32'(lat_s), 32'((o == 1) ? oh : '0));
        chk({tag, "_setup_r"}, 32'(lat_r), 32'((o == 2) ? oh : '0));
        if (early) req[w] = 1'b0;
      end
      if (wr && lat == SC + 2)
        chk({tag, "_release_hold"}, 32'(lat_s | lat_r), 32'(oh));
    end while (ack == '0 && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_ack"},     32'(ack), 32'(1 << w));
    chk({tag, "_err"},     32'(err), 32'(e_err));
    chk({tag, "_rd_q"},    32'(rd_q), 32'(e_rd));
    chk({tag, "_strobe"},  32'(c_any), 32'(wr ? SC : 0));
    chk({tag, "_strobe_idx"}, 32'(c_ix), 32'(wr ? SC : 0));
    chk({tag, "_sr_clear"}, 32'(lat_s | lat_r), 0);
    ptr_m = (w + 1) % NR;
    if (!hold) req[w] = 1'b0;
  endtask

  initial begin
    int n, cnt;
    logic [NR-1:0] m;
    do_reset(1'b1);

    // Single SET, then CLEAR and READ back of the same flag.
    set_op(0, 2'b01, 3'd3); req[0] = 1'b1; serve("t1_set", 0, 0);
    set_op(1, 2'b10, 3'd3); req[1] = 1'b1; serve("t2_clr", 0, 0);
    set_op(1, 2'b00, 3'd3); req[1] = 1'b1; serve("t2_rd",  0, 0);

    // Four simultaneous SETs from a fresh pointer; requester 0 keeps asking.
    do_reset(1'b0);
    set_op(0, 2'b01, 3'd0); set_op(1, 2'b01, 3'd1);
    set_op(2, 2'b01, 3'd2); set_op(3, 2'b01, 3'd4);
    req = '1;
    serve("t3_g1", 1, 0);
    serve("t3_g2", 0, 0);
    serve("t3_g3", 0, 0);
    serve("t3_g4", 0, 0);
    serve("t3_g5", 0, 0);

    // Reserved op and out-of-range index.
    set_op(1, 2'b11, 3'd2); req[1] = 1'b1; serve("t4_rsv", 0, 0);
    set_op(2, 2'b01, 3'd7); req[2] = 1'b1; serve("t4_oor", 0, 0);

    // Flag 5 stuck at 0.
    stuck0[5] = 1'b1;
    set_op(3, 2'b01, 3'd5); req[3] = 1'b1; serve("t5_stuck", 0, 0);

    // Reset mid-strobe (flag 0 already holds 1, so its content is unaffected).
    set_op(2, 2'b01, 3'd0); req[2] = 1'b1;
    n = 0;
    while (lat_c == '0 && n < 20) begin @(negedge clk); n++; end
    chk("t6_reach_strobe", 32'(lat_c), 32'b1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("t6_async_c",    32'(lat_c), 0);
    chk("t6_async_busy", 32'(busy),  0);
    chk("t6_async_s",    32'(lat_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    set_op(0, 2'b00, 3'd0); set_op(2, 2'b00, 3'd3);
    req[0] = 1'b1; req[2] = 1'b1;
    serve("t6_post_a", 0, 0);
    serve("t6_post_b", 0, 0);

    // Random batches, occasionally dropping req before ack.
    for (int r = 0; r < 25; r++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      cnt = 0;
      for (int i = 0; i < NR; i++)
        if (m[i]) begin
          set_op(i, 2'($urandom_range(0, 3)), IW'($urandom_range(0, 7)));
          cnt++;
        end
      req = m;
      for (int k = 0; k < cnt; k++) serve("rnd", 0, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
